// File: rtl/onchip_memory_test_master.sv
// Avalon-MM memory BIST master: writes a seed-derived pattern over a word range,
// reads it back one word at a time and reports pass/fail, error count and first bad address.
module onchip_memory_test_master #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int ERR_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
);

  localparam int IDX_W = ADDR_W + 1;
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_pattern;
  logic              last_word;
  logic              timed_out;
  logic              word_bad;

  // Index occupies both halves of the low 32 bits so stuck or shorted data lines show up.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [DATA_W-1:0] s,
                                                     input logic [IDX_W-1:0]  i);
    logic [15:0] i16;
    i16 = 16'(i);
    return s ^ DATA_W'({i16, ~i16});
  endfunction

  assign cur_addr    = base_q + idx_q[ADDR_W-1:0];
  assign cur_pattern = pattern_word(seed_q, idx_q);
  assign last_word   = (idx_q + IDX_ONE) == count_q;
  assign timed_out   = timer_q == TMR_MAX;
  // When data and timeout coincide, the data decides the outcome.
  assign word_bad    = avm_readdatavalid ? (avm_readdata != cur_pattern) : timed_out;

  // NOTE: every *_d starts as its *_q so no branch leaves a value unassigned (no latches).
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    timer_d = timer_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = word_count;
          seed_d  = seed;
          idx_d   = '0;
          timer_d = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          if (word_count == '0) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (last_word) begin
            idx_d   = '0;
            state_d = S_READ_REQ;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      S_READ_REQ: begin
        if (!avm_waitrequest) begin
          timer_d = '0;
          state_d = S_READ_WAIT;
        end
      end

      S_READ_WAIT: begin
        timer_d = timer_q + TMR_ONE;
        if (avm_readdatavalid || timed_out) begin
          if (word_bad) begin
            if (err_q == '0) first_d = cur_addr;
            if (err_q != '1) err_d = err_q + ERR_ONE;
          end
          if (last_word) begin
            pass_d  = (err_d == '0);
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_READ_REQ;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      seed_q  <= '0;
      timer_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  // Bus outputs derive only from registered state, so they hold steady under waitrequest.
  assign busy           = state_q inside {S_WRITE, S_READ_REQ, S_READ_WAIT};
  assign done           = state_q == S_DONE;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign avm_write      = state_q == S_WRITE;
  assign avm_read       = state_q == S_READ_REQ;
  assign avm_address    = (avm_write || avm_read) ? cur_addr : '0;
  assign avm_writedata  = avm_write ? cur_pattern : '0;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_onchip_memory_test_master.sv
// Self-checking bench: behavioural RAM slave with random stalls/faults and a
// specification-level model of the expected write/read sequence and final result.
module tb_onchip_memory_test_master;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int ERR_W  = 16;
  localparam int LIMIT  = 4000;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  onchip_memory_test_master dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .seed              (seed),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [15:0] v;
    v = 16'(i);
    return s ^ {v, ~v};
  endfunction

  // Slave behaviour knobs
  logic [31:0]       mem [8192];
  int unsigned       wr_pct  = 0;
  bit                no_resp = 0;
  bit                spur_en = 0;
  bit                flip_en = 0;
  logic [ADDR_W-1:0] flip_addr = '0;
  bit                rd_pend = 0;
  logic [ADDR_W-1:0] rd_addr = '0;

  // Expected-run state shared with the compare process
  logic [ADDR_W-1:0] exp_base = '0;
  int                exp_n    = 0;
  logic [31:0]       exp_seed = '0;
  int                w_idx    = 0;
  int                r_idx    = 0;

  // RAM slave: decides waitrequest mid-cycle, answers an accepted read one cycle later.
  initial begin : slave
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (!reset_n) rd_pend = 0;
      if (rd_pend && !no_resp) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem[rd_addr] ^ ((flip_en && rd_addr == flip_addr) ? 32'd1 : 32'd0);
      end else if (spur_en && !rd_pend && $urandom_range(3) == 0) begin
        avm_readdatavalid = 1'b1;
      end
      rd_pend = 0;
      avm_waitrequest = reset_n && ($urandom_range(99) < wr_pct);
      if (reset_n) begin
        if (avm_write && !avm_waitrequest) mem[avm_address] = avm_writedata;
        if (avm_read && !avm_waitrequest) begin
          rd_pend = 1;
          rd_addr = avm_address;
        end
      end
    end
  end

  // Compare process: checks every accepted transfer and stall stability against the model.
  initial begin : compare
    logic              prev_stall;
    logic              prev_rd;
    logic              prev_wr;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [ADDR_W-1:0] ea;
    prev_stall = 0;
    prev_rd    = 0;
    prev_wr    = 0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stall stable", {avm_read, avm_write, avm_address, avm_writedata},
                {prev_rd, prev_wr, prev_addr, prev_data});
        if (avm_write && !avm_waitrequest) begin
          ea = exp_base + 13'(w_idx);
          check("write index in range", 64'(w_idx < exp_n), 64'd1);
          check("write addr", avm_address, ea);
          check("write data", avm_writedata, pat(exp_seed, w_idx));
          w_idx++;
        end
        if (avm_read && !avm_waitrequest) begin
          ea = exp_base + 13'(r_idx);
          check("read after all writes", 64'(w_idx), 64'(exp_n));
          check("read index in range", 64'(r_idx < exp_n), 64'd1);
          check("read addr", avm_address, ea);
          r_idx++;
        end
        if (!busy) check("idle bus quiet", {avm_read, avm_write}, 2'b00);
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_rd    = avm_read;
        prev_wr    = avm_write;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
      end
    end
  end

  // One complete test: model prediction, start pulse, bounded wait for done, result checks.
  task automatic run_test(input string name, input logic [ADDR_W-1:0] b,
                          input logic [ADDR_W:0] n, input logic [31:0] s, input int exp_lat);
    logic [ERR_W-1:0]  e_err;
    logic [ADDR_W-1:0] e_first;
    logic [ADDR_W-1:0] a;
    int                k;
    bit                got;
    e_err   = '0;
    e_first = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 13'(i);
      if (no_resp || (flip_en && a == flip_addr)) begin
        if (e_err == '0) e_first = a;
        if (e_err != '1) e_err++;
      end
    end
    exp_base = b;
    exp_n    = int'(n);
    exp_seed = s;
    w_idx    = 0;
    r_idx    = 0;

    @(negedge clk);
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    seed       = s;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = 13'($urandom);
    word_count = 14'($urandom);
    seed       = $urandom;

    k   = 0;
    got = 0;
    while (!got && k < LIMIT) begin
      #1;
      if (done) begin
        got = 1;
      end else begin
        check({name, " busy/pass while running"}, {busy, pass}, 2'b10);
        start = (k == 3);
        k++;
        @(negedge clk);
      end
    end
    start = 1'b0;

    check({name, " done seen"}, 64'(got), 64'd1);
    if (got) begin
      if (exp_lat >= 0) check({name, " cycles to done"}, 64'(k), 64'(exp_lat));
      check({name, " busy low at done"}, busy, 1'b0);
      check({name, " pass"}, pass, e_err == '0);
      check({name, " err_count"}, err_count, e_err);
      check({name, " first_err_addr"}, first_err_addr, e_first);
      check({name, " writes"}, 64'(w_idx), 64'(n));
      check({name, " reads"}, 64'(r_idx), 64'(n));
      @(negedge clk);
      #1;
      check({name, " done one cycle"}, done, 1'b0);
      check({name, " pass held"}, pass, e_err == '0);
    end
  endtask

  initial begin : driver
    logic [ADDR_W-1:0] b;
    logic [ADDR_W:0]   n;
    logic [31:0]       s;
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    seed       = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset ctl", {busy, done, pass, avm_read, avm_write, err_count, first_err_addr, avm_address}, 64'd0);
    check("reset wdata", avm_writedata, 32'd0);
    check("reset byteenable", avm_byteenable, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;

    // Ideal RAM, 16 words from 0, seed 0
    run_test("t1", 13'd0, 14'd16, 32'd0, 48);
    check("t1 word5", mem[5], 32'h0005FFFA);
    check("t1 word0", mem[0], 32'h0000FFFF);

    // Bit-0 fault at address 7
    flip_en   = 1;
    flip_addr = 13'd7;
    run_test("t2", 13'd4, 14'd8, $urandom, 24);
    check("t2 literal err", err_count, 16'd1);
    check("t2 literal first", first_err_addr, 13'd7);
    flip_en = 0;

    // Address wrap at the top of memory
    s = $urandom;
    run_test("t3", 13'd8190, 14'd4, s, 12);
    check("t3 wrap word8191", mem[8191], pat(s, 1));
    check("t3 wrap word0", mem[0], pat(s, 2));
    check("t3 wrap word1", mem[1], pat(s, 3));

    // Random stalls, stray readdatavalid, occasional fault
    wr_pct  = 50;
    spur_en = 1;
    for (int t = 0; t < 8; t++) begin
      b         = (t == 0) ? 13'd8180 : 13'($urandom);
      n         = 14'($urandom_range(1, 40));
      flip_en   = (t % 3 == 2);
      flip_addr = b + 13'($urandom_range(0, int'(n) - 1));
      run_test("t4", b, n, $urandom, -1);
    end
    flip_en = 0;
    spur_en = 0;
    wr_pct  = 0;

    // Slave never answers
    no_resp = 1;
    run_test("t5", 13'd100, 14'd2, $urandom, -1);
    check("t5 literal err", err_count, 16'd2);
    check("t5 literal first", first_err_addr, 13'd100);
    no_resp = 0;

    // Zero-length test
    run_test("t6", 13'($urandom), 14'd0, $urandom, 0);

    // Reset in the middle of the write phase
    exp_base = 13'd300;
    exp_n    = 16;
    exp_seed = 32'h1234_5678;
    w_idx    = 0;
    r_idx    = 0;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = 13'd300;
    word_count = 14'd16;
    seed       = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("mid write active", avm_write, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort ctl", {busy, done, pass, avm_read, avm_write, err_count, first_err_addr, avm_address}, 64'd0);
    check("abort wdata", avm_writedata, 32'd0);
    check("abort byteenable", avm_byteenable, 4'hF);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("no done in reset", done, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("no done after abort", {done, busy}, 2'b00);
    end

    run_test("post reset", 13'($urandom), 14'd10, $urandom, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
